sweep_square_channel: RTL and testbench

//  Parametrised square-wave tone channel: programmable period timer drives an 8-step duty

---
 rtl/sweep_square_channel_pkg.sv | 29 ++
 rtl/sweep_square_channel_sweep_unit.sv | 86 ++++++++
 rtl/sweep_square_channel.sv | 136 +++++++++++++
 tb/tb_sweep_square_channel.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sweep_square_channel_pkg.sv
// Shared definitions for the square-wave tone channel.
//   state_e        : channel FSM encoding (IDLE / RUN / MUTED)
//   MIN_PERIOD_DEF : default lowest audible period; smaller periods mute
//   DUTY_TABLE     : 4 duty patterns x 8 steps, written step 0 .. step 7
//                    left to right (so step s lives at bit 7-s)
package sweep_square_channel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_MUTED = 2'd2
  } state_e;

  localparam int unsigned MIN_PERIOD_DEF = 8;

  // Index [duty][bit]; entry 3 is the MSB of the concatenation.
  localparam logic [3:0][7:0] DUTY_TABLE = {
    8'b11111100,   // 3: 75%
    8'b00001111,   // 2: 50%
    8'b00000011,   // 1: 25%
    8'b00000001    // 0: 12.5%
  };

  // Step s of the pattern sits at bit 7-s.
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    return DUTY_TABLE[duty][3'd7 - step];
  endfunction

endpackage

// File: rtl/sweep_square_channel_sweep_unit.sv
// Sweep unit: synchronises the frame tick, detects its rising edge, runs the
// sweep divider and computes the next swept period.
//   clk, rst          : clock, async active-high reset
//   tick_i            : asynchronous frame tick level
//   run_i             : channel is in RUN (sweep frozen otherwise)
//   load_i            : qualified load strobe (reloads the divider)
//   sweep_enable_i    : sweep updates allowed
//   mode_i            : 0 add, 1 subtract
//   shift_i           : delta = cur >> shift (0 disables)
//   swp_period_i      : divider reload (0 disables)
//   cur_period_i      : current period
//   new_period_o      : candidate swept period
//   update_o          : apply new_period_o this cycle
//   overflow_o        : add-mode target exceeds the period range
module sweep_unit #(
  parameter int unsigned PERIOD_W  = 11,
  parameter int unsigned SHIFT_W   = 3,
  parameter int unsigned SWP_PER_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 run_i,
  input  logic                 load_i,
  input  logic                 sweep_enable_i,
  input  logic                 mode_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  input  logic [SWP_PER_W-1:0] swp_period_i,
  input  logic [PERIOD_W-1:0]  cur_period_i,
  output logic [PERIOD_W-1:0]  new_period_o,
  output logic                 update_o,
  output logic                 overflow_o
);

  logic                 sync1_q, sync2_q, sync3_q;
  logic                 edge_s;
  logic [SWP_PER_W-1:0] div_q, div_d;
  logic [PERIOD_W:0]    cur_ext_s, delta_s, target_s;
  logic                 active_s;

  // Edge is seen while sync2 is set and sync3 not yet, so the update lands
  // on the third clock after the tick rises.
  assign edge_s = sync2_q & ~sync3_q;

  // One extra bit so an add-mode carry is visible as overflow.
  assign cur_ext_s = {1'b0, cur_period_i};
  assign delta_s   = cur_ext_s >> shift_i;
  assign target_s  = mode_i ? (cur_ext_s - delta_s) : (cur_ext_s + delta_s);

  assign active_s     = run_i & sweep_enable_i & (shift_i != {SHIFT_W{1'b0}});
  assign overflow_o   = active_s & ~mode_i & target_s[PERIOD_W];
  assign new_period_o = target_s[PERIOD_W-1:0];
  assign update_o     = edge_s & active_s & (div_q == {SWP_PER_W{1'b0}})
                      & (swp_period_i != {SWP_PER_W{1'b0}}) & ~overflow_o & ~load_i;

  // Divider: load reloads it; otherwise it only steps on tick edges in RUN.
  always_comb begin
    div_d = div_q;
    if (load_i) begin
      div_d = swp_period_i;
    end else if (edge_s & run_i) begin
      if (div_q == {SWP_PER_W{1'b0}}) begin
        div_d = swp_period_i;
      end else begin
        div_d = div_q - {{(SWP_PER_W-1){1'b0}}, 1'b1};
      end
    end else begin
      div_d = div_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      div_q   <= {SWP_PER_W{1'b0}};
    end else begin
      sync1_q <= tick_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/sweep_square_channel.sv
// Square-wave tone channel: period timer, 8-step duty sequencer, FSM and
// frequency sweep.
//   clk, reset      : clock, async active-high reset
//   iEnable         : channel enable (low forces IDLE, beats iLoad)
//   iLoad, iPeriod  : load strobe and period value
//   iDuty           : duty select
//   iSweep_*        : sweep tick / enable / mode / shift / divider reload
//   oData           : square-wave output (registered)
//   oMuted          : channel is MUTED
//   oPeriod         : current (swept) period
module sweep_square_channel
  import sweep_square_channel_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 11,
  parameter int unsigned SHIFT_W    = 3,
  parameter int unsigned SWP_PER_W  = 3,
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iEnable,
  input  logic                 iLoad,
  input  logic [PERIOD_W-1:0]  iPeriod,
  input  logic [1:0]           iDuty,
  input  logic                 iSweep_tick,
  input  logic                 iSweep_enable,
  input  logic                 iSweep_mode,
  input  logic [SHIFT_W-1:0]   iSweep_shift,
  input  logic [SWP_PER_W-1:0] iSweep_period,
  output logic                 oData,
  output logic                 oMuted,
  output logic [PERIOD_W-1:0]  oPeriod
);

  state_e               state_q, state_d;
  logic [PERIOD_W-1:0]  cur_q, cur_d;
  logic [PERIOD_W-1:0]  timer_q, timer_d;
  logic [2:0]           step_q, step_d;
  logic                 data_q, data_d;
  logic                 load_s, valid_s;
  logic [PERIOD_W-1:0]  new_period_s;
  logic                 update_s, overflow_s;

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

  assign load_s  = iLoad & iEnable;
  assign valid_s = (iPeriod >= MIN_P);

  sweep_unit #(
    .PERIOD_W  (PERIOD_W),
    .SHIFT_W   (SHIFT_W),
    .SWP_PER_W (SWP_PER_W)
  ) u_sweep (
    .clk            (clk),
    .rst            (reset),
    .tick_i         (iSweep_tick),
    .run_i          (state_q == ST_RUN),
    .load_i         (load_s),
    .sweep_enable_i (iSweep_enable),
    .mode_i         (iSweep_mode),
    .shift_i        (iSweep_shift),
    .swp_period_i   (iSweep_period),
    .cur_period_i   (cur_q),
    .new_period_o   (new_period_s),
    .update_o       (update_s),
    .overflow_o     (overflow_s)
  );

  // Next-state logic: disable first, then load, then RUN mute conditions.
  always_comb begin
    state_d = state_q;
    if (!iEnable) begin
      state_d = ST_IDLE;
    end else if (iLoad) begin
      state_d = valid_s ? ST_RUN : ST_MUTED;
    end else begin
      case (state_q)
        ST_RUN:   if (overflow_s || (cur_q < MIN_P)) state_d = ST_MUTED;
                  else                                state_d = ST_RUN;
        ST_MUTED: state_d = ST_MUTED;
        ST_IDLE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: period register, timer/step sequencer and output bit.
  always_comb begin
    cur_d   = cur_q;
    timer_d = timer_q;
    step_d  = step_q;
    if (load_s) begin
      cur_d = iPeriod;
    end else if (update_s) begin
      cur_d = new_period_s;
    end else begin
      cur_d = cur_q;
    end
    if (load_s) begin
      timer_d = iPeriod;
      step_d  = 3'd0;
    end else if (state_q != ST_IDLE) begin
      // Reload picks up the latest period; a running count is never cut short.
      if (timer_q == {PERIOD_W{1'b0}}) begin
        timer_d = cur_q;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q - {{(PERIOD_W-1){1'b0}}, 1'b1};
      end
    end else begin
      timer_d = timer_q;
    end
    data_d = (state_q == ST_RUN) ? duty_bit(iDuty, step_q) : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= {PERIOD_W{1'b0}};
      timer_q <= {PERIOD_W{1'b0}};
      step_q  <= 3'd0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      data_q  <= data_d;
    end
  end

  assign oData   = data_q;
  assign oMuted  = (state_q == ST_MUTED);
  assign oPeriod = cur_q;

endmodule

// File: tb/tb_sweep_square_channel.sv
module tb_sweep_square_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, ld = 1'b0, tick = 1'b0, swe = 1'b0, mode = 1'b0;
  logic [10:0] per = 11'd0;
  logic [1:0]  duty = 2'd0;
  logic [2:0]  sh = 3'd0, sp = 3'd0;
  logic        oData, oMuted;
  logic [10:0] oPeriod;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic data; logic muted; logic [10:0] period; } exp_t;
  exp_t exp_q[$];

  // reference model state: 0 idle, 1 run, 2 muted
  int m_state, m_cur, m_timer, m_step, m_div;
  bit m_t1, m_t2, m_t3;

  sweep_square_channel dut (
    .clk(clk), .reset(rst), .iEnable(en), .iLoad(ld), .iPeriod(per), .iDuty(duty),
    .iSweep_tick(tick), .iSweep_enable(swe), .iSweep_mode(mode),
    .iSweep_shift(sh), .iSweep_period(sp),
    .oData(oData), .oMuted(oMuted), .oPeriod(oPeriod)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // high-level duty rule: fraction of the 8 steps that are high, position from the table
  function automatic bit duty_pat(input int d, input int s);
    case (d)
      0: return s >= 7;
      1: return s >= 6;
      2: return s >= 4;
      default: return s <= 5;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_timer = 0; m_step = 0; m_div = 0;
    m_t1 = 0; m_t2 = 0; m_t3 = 0;
  endtask

  // advance one clock: predict, wait for the edge, then queue the prediction
  task automatic cycle();
    exp_t e;
    int n_state, n_cur, n_timer, n_step, n_div, delta, tgt;
    bit edge_seen, active, ovf, upd, load;
    if (rst) begin
      model_reset();
      e = '0;
    end else begin
      edge_seen = m_t2 && !m_t3;
      delta  = m_cur >> sh;
      tgt    = mode ? m_cur - delta : m_cur + delta;
      active = (m_state == 1) && swe && (sh != 0);
      ovf    = active && !mode && (tgt > 2047);
      load   = ld && en;
      upd    = edge_seen && active && (m_div == 0) && (sp != 0) && !ovf && !load;
      if (!en)                                        n_state = 0;
      else if (ld)                                    n_state = (per >= 8) ? 1 : 2;
      else if (m_state == 1 && (ovf || m_cur < 8))    n_state = 2;
      else                                            n_state = m_state;
      n_cur = load ? int'(per) : (upd ? tgt : m_cur);
      n_timer = m_timer; n_step = m_step;
      if (load) begin n_timer = per; n_step = 0; end
      else if (m_state != 0) begin
        if (m_timer == 0) begin n_timer = m_cur; n_step = (m_step + 1) % 8; end
        else n_timer = m_timer - 1;
      end
      n_div = m_div;
      if (load) n_div = sp;
      else if (edge_seen && m_state == 1) n_div = (m_div == 0) ? int'(sp) : m_div - 1;
      e.data   = (m_state == 1) ? duty_pat(duty, m_step) : 1'b0;
      e.muted  = (n_state == 2);
      e.period = n_cur[10:0];
      m_state = n_state; m_cur = n_cur; m_timer = n_timer; m_step = n_step; m_div = n_div;
      m_t3 = m_t2; m_t2 = m_t1; m_t1 = tick;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // monitor: compare DUT outputs against queued predictions on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("oData",   oData,   e.data);
      chk("oMuted",  oMuted,  e.muted);
      chk("oPeriod", oPeriod, e.period);
    end
  end

  task automatic load(input int p);
    per = p[10:0]; ld = 1'b1; cycle(); ld = 1'b0;
  endtask

  task automatic send_tick();
    tick = 1'b1; cycles(6); tick = 1'b0; cycles(6);
  endtask

  task automatic mid_reset(input string tag);
    rst = 1'b1; #1;
    chk({tag, "_data"},   oData,   0);
    chk({tag, "_muted"},  oMuted,  0);
    chk({tag, "_period"}, oPeriod, 0);
    exp_q.delete();
    model_reset();
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic count_high(input string name, input int n, input int expv);
    int hi = 0;
    for (int i = 0; i < n; i++) begin cycle(); hi += oData; end
    chk(name, hi, expv);
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_data", oData, 0); chk("reset_muted", oMuted, 0); chk("reset_period", oPeriod, 0);
    cycles(3);
    rst = 1'b0;
    cycles(2);
    en = 1'b1;

    // 50% duty, period 15: 64 high in every 128 clocks
    duty = 2'd2; load(15); cycles(128);
    count_high("duty50_high", 128, 64);
    mid_reset("rst_run");

    // 12.5% duty, period 9: 10 high in every 80 clocks
    duty = 2'd0; load(9); cycles(80);
    count_high("duty12_high", 80, 10);

    // add sweep: 0x400 -> 0x600, next target 0x900 overflows and mutes
    swe = 1'b1; mode = 1'b0; sh = 3'd1; sp = 3'd1;
    load(11'h400); send_tick(); chk("add_odd_tick", oPeriod, 11'h400);
    send_tick(); cycles(4);
    chk("add_period", oPeriod, 11'h600); chk("add_muted", oMuted, 1); chk("add_data", oData, 0);
    mid_reset("rst_muted");

    // subtract sweep: 100 -> 75 -> 57, only on every second tick
    en = 1'b1; mode = 1'b1; sh = 3'd2; sp = 3'd1;
    load(100); send_tick(); chk("sub_tick1", oPeriod, 100);
    send_tick(); chk("sub_tick2", oPeriod, 75);
    send_tick(); chk("sub_tick3", oPeriod, 75);
    send_tick(); chk("sub_tick4", oPeriod, 57);

    // load on the same clock as an update-carrying sweep edge: load wins
    load(100); send_tick();
    tick = 1'b1; cycles(2); load(200); cycles(3); tick = 1'b0; cycles(6);
    chk("collide_period", oPeriod, 200);
    send_tick(); chk("collide_reload", oPeriod, 200);
    send_tick(); chk("collide_next", oPeriod, 150);

    // MIN_PERIOD boundary and enable
    swe = 1'b0;
    load(5); cycles(2); chk("p5_muted", oMuted, 1);
    load(8); cycles(2); chk("p8_muted", oMuted, 0);
    load(7); cycles(2); chk("p7_muted", oMuted, 1);
    en = 1'b0; cycles(3); chk("dis_muted", oMuted, 0); chk("dis_data", oData, 0);
    en = 1'b1; load(20); cycles(20);

    // randomized phase against the reference model
    for (int i = 0; i < 6000; i++) begin
      en = ($urandom_range(0, 99) >= 3);
      ld = ($urandom_range(0, 99) < 3);
      if (ld) case ($urandom_range(0, 2))
        0: per = 11'($urandom_range(0, 20));
        1: per = 11'($urandom_range(1024, 2047));
        default: per = 11'($urandom_range(0, 300));
      endcase
      if ($urandom_range(0, 9) == 0) tick = ~tick;
      if ($urandom_range(0, 49) == 0) begin
        swe = ($urandom_range(0, 4) != 0); mode = 1'($urandom_range(0, 1));
        sh = 3'($urandom_range(0, 7)); sp = 3'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 19) == 0) duty = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) < 2) mid_reset("rst_rand");
      else cycle();
    end
    ld = 1'b0;
    cycles(2);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
